// File: rtl/axi_matmul_stream_core.sv
// Streaming matrix multiply C = A * B with runtime M/K/N up to MAX_DIM; A/B buffered, C streamed row-major.
// Optional macro SATURATE_EN: clamp C to the DATA_W signed range instead of truncating.
module axi_matmul_stream_core #(
  parameter int DATA_W  = 16,
  parameter int MAX_DIM = 8,
  parameter int ACC_W   = 2*DATA_W + $clog2(MAX_DIM),
  parameter int DIM_W   = $clog2(MAX_DIM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_m,
  input  logic [DIM_W-1:0]  cfg_k,
  input  logic [DIM_W-1:0]  cfg_n,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  input  logic              s_axis_a_tvalid,
  output logic              s_axis_a_tready,
  input  logic [DATA_W-1:0] s_axis_a_tdata,
  input  logic              s_axis_a_tlast,
  input  logic              s_axis_b_tvalid,
  output logic              s_axis_b_tready,
  input  logic [DATA_W-1:0] s_axis_b_tdata,
  input  logic              s_axis_b_tlast,
  output logic              m_axis_c_tvalid,
  input  logic              m_axis_c_tready,
  output logic [DATA_W-1:0] m_axis_c_tdata,
  output logic              m_axis_c_tlast
);

  localparam int DEPTH = MAX_DIM * MAX_DIM;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_OUTPUT, S_DONE} state_t;

  state_t             state_reg;
  logic [DIM_W-1:0]   m_reg, k_reg, n_reg;
  logic [CW-1:0]      mk_reg, kn_reg, a_cnt_reg, b_cnt_reg;
  logic               a_ready_reg, b_ready_reg;
  logic [DIM_W-1:0]   i_reg, j_reg, k_cnt_reg;
  logic [AW-1:0]      a_row_reg, a_ptr_reg, b_ptr_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic [DATA_W-1:0]  c_data_reg;
  logic               c_valid_reg, c_last_reg;
  logic               busy_reg, done_reg;
  logic [1:0]         status_reg;

  logic signed [DATA_W-1:0] a_mem [DEPTH];
  logic signed [DATA_W-1:0] b_mem [DEPTH];
  logic signed [DATA_W-1:0] a_rd, b_rd;

  logic a_fire, b_fire, a_final, b_final, a_complete, b_complete, cfg_bad;
  assign a_fire     = s_axis_a_tvalid && a_ready_reg;
  assign b_fire     = s_axis_b_tvalid && b_ready_reg;
  assign a_final    = (a_cnt_reg == mk_reg - CW'(1));
  assign b_final    = (b_cnt_reg == kn_reg - CW'(1));
  assign a_complete = !a_ready_reg || (a_fire && a_final);
  assign b_complete = !b_ready_reg || (b_fire && b_final);
  assign cfg_bad    = (cfg_m == '0) || (cfg_k == '0) || (cfg_n == '0) ||
                      (cfg_m > DIM_W'(MAX_DIM)) || (cfg_k > DIM_W'(MAX_DIM)) ||
                      (cfg_n > DIM_W'(MAX_DIM));

  // Buffers have no reset so they map onto block RAM with a registered read port.
  always_ff @(posedge clk) begin
    if (a_fire) a_mem[a_cnt_reg[AW-1:0]] <= s_axis_a_tdata;
    if (b_fire) b_mem[b_cnt_reg[AW-1:0]] <= s_axis_b_tdata;
    a_rd <= a_mem[a_ptr_reg];
    b_rd <= b_mem[b_ptr_reg];
  end

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext, acc_base, acc_sum;
  logic [DATA_W-1:0]          c_next;

`ifdef SATURATE_EN
  localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'((2**(DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] C_MIN = ACC_W'(-(2**(DATA_W-1)));
`endif

  always_comb begin
    prod     = a_rd * b_rd;
    prod_ext = ACC_W'(prod);
    acc_base = (k_cnt_reg == DIM_W'(1)) ? '0 : acc_reg;
    acc_sum  = acc_base + prod_ext;
`ifdef SATURATE_EN
    if (acc_sum > C_MAX)      c_next = C_MAX[DATA_W-1:0];
    else if (acc_sum < C_MIN) c_next = C_MIN[DATA_W-1:0];
    else                      c_next = acc_sum[DATA_W-1:0];
`else
    c_next = acc_sum[DATA_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      m_reg       <= '0;
      k_reg       <= '0;
      n_reg       <= '0;
      mk_reg      <= '0;
      kn_reg      <= '0;
      a_cnt_reg   <= '0;
      b_cnt_reg   <= '0;
      a_ready_reg <= 1'b0;
      b_ready_reg <= 1'b0;
      i_reg       <= '0;
      j_reg       <= '0;
      k_cnt_reg   <= '0;
      a_row_reg   <= '0;
      a_ptr_reg   <= '0;
      b_ptr_reg   <= '0;
      acc_reg     <= '0;
      c_data_reg  <= '0;
      c_valid_reg <= 1'b0;
      c_last_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      status_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            m_reg     <= cfg_m;
            k_reg     <= cfg_k;
            n_reg     <= cfg_n;
            mk_reg    <= CW'(cfg_m) * CW'(cfg_k);
            kn_reg    <= CW'(cfg_k) * CW'(cfg_n);
            a_cnt_reg <= '0;
            b_cnt_reg <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            k_cnt_reg <= '0;
            a_row_reg <= '0;
            a_ptr_reg <= '0;
            b_ptr_reg <= '0;
            if (cfg_bad) begin
              status_reg <= 2'b01;
              done_reg   <= 1'b1;
              state_reg  <= S_DONE;
            end else begin
              status_reg  <= 2'b00;
              done_reg    <= 1'b0;
              a_ready_reg <= 1'b1;
              b_ready_reg <= 1'b1;
              busy_reg    <= 1'b1;
              state_reg   <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          // The beat count alone ends the load; a misplaced tlast is only flagged.
          if (a_fire) begin
            a_cnt_reg <= a_cnt_reg + CW'(1);
            if (s_axis_a_tlast != a_final) status_reg[1] <= 1'b1;
            if (a_final) a_ready_reg <= 1'b0;
          end
          if (b_fire) begin
            b_cnt_reg <= b_cnt_reg + CW'(1);
            if (s_axis_b_tlast != b_final) status_reg[1] <= 1'b1;
            if (b_final) b_ready_reg <= 1'b0;
          end
          if (a_complete && b_complete) state_reg <= S_COMPUTE;
        end
        S_COMPUTE: begin
          // Cycle 0 only issues the first read; cycles 1..K each accumulate one product.
          k_cnt_reg <= k_cnt_reg + DIM_W'(1);
          if ((k_cnt_reg + DIM_W'(1)) < k_reg) begin
            a_ptr_reg <= a_ptr_reg + AW'(1);
            b_ptr_reg <= b_ptr_reg + AW'(n_reg);
          end
          if (k_cnt_reg != '0) acc_reg <= acc_sum;
          if (k_cnt_reg == k_reg) begin
            c_data_reg  <= c_next;
            c_valid_reg <= 1'b1;
            c_last_reg  <= (i_reg == m_reg - DIM_W'(1)) && (j_reg == n_reg - DIM_W'(1));
            state_reg   <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (m_axis_c_tready) begin
            c_valid_reg <= 1'b0;
            c_last_reg  <= 1'b0;
            k_cnt_reg   <= '0;
            if (j_reg == n_reg - DIM_W'(1)) begin
              j_reg     <= '0;
              b_ptr_reg <= '0;
              if (i_reg == m_reg - DIM_W'(1)) begin
                done_reg  <= 1'b1;
                busy_reg  <= 1'b0;
                state_reg <= S_DONE;
              end else begin
                i_reg     <= i_reg + DIM_W'(1);
                a_row_reg <= a_row_reg + AW'(k_reg);
                a_ptr_reg <= a_row_reg + AW'(k_reg);
                state_reg <= S_COMPUTE;
              end
            end else begin
              j_reg     <= j_reg + DIM_W'(1);
              b_ptr_reg <= AW'(j_reg) + AW'(1);
              a_ptr_reg <= a_row_reg;
              state_reg <= S_COMPUTE;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy            = busy_reg;
  assign done            = done_reg;
  assign status          = status_reg;
  assign s_axis_a_tready = a_ready_reg;
  assign s_axis_b_tready = b_ready_reg;
  assign m_axis_c_tvalid = c_valid_reg;
  assign m_axis_c_tdata  = c_data_reg;
  assign m_axis_c_tlast  = c_last_reg;

endmodule

// File: tb/tb_axi_matmul_stream_core.sv
// Directed bench for axi_matmul_stream_core: fixed matrices with hand-computed C, stalls, bad cfg, reset.
module tb_axi_matmul_stream_core;

  localparam int DATA_W = 16;
  localparam int DIM_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, busy, done;
  logic [DIM_W-1:0]  cfg_m, cfg_k, cfg_n;
  logic [1:0]        status;
  logic              a_tvalid, a_tready, a_tlast, b_tvalid, b_tready, b_tlast;
  logic              c_tvalid, c_tready, c_tlast;
  logic [DATA_W-1:0] a_tdata, b_tdata, c_tdata;

  axi_matmul_stream_core dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
    .busy(busy), .done(done), .status(status),
    .s_axis_a_tvalid(a_tvalid), .s_axis_a_tready(a_tready),
    .s_axis_a_tdata(a_tdata), .s_axis_a_tlast(a_tlast),
    .s_axis_b_tvalid(b_tvalid), .s_axis_b_tready(b_tready),
    .s_axis_b_tdata(b_tdata), .s_axis_b_tlast(b_tlast),
    .m_axis_c_tvalid(c_tvalid), .m_axis_c_tready(c_tready),
    .m_axis_c_tdata(c_tdata), .m_axis_c_tlast(c_tlast)
  );

  int checks = 0;
  int failures = 0;
  int a_vec [64];
  int b_vec [64];
  int c_exp [64];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_status"}, status, 0);
    check({tag, "_a_ready"}, a_tready, 0);
    check({tag, "_b_ready"}, b_tready, 0);
    check({tag, "_c_valid"}, c_tvalid, 0);
    check({tag, "_c_last"}, c_tlast, 0);
    check({tag, "_c_data"}, c_tdata, 0);
  endtask

  task automatic pulse_start(input int m, input int k, input int n);
    cfg_m = DIM_W'(m);
    cfg_k = DIM_W'(k);
    cfg_n = DIM_W'(n);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_case(input string name, input int m, input int k, input int n, input bit rnd,
                          input int a_last_idx, input int rst_after, input int exp_status);
    int a_sent, b_sent, c_got, load_cyc;
    bit load_seen, c_seen, stalled, finished, a_f, b_f, c_f;
    logic [DATA_W-1:0] held;
    a_sent = 0; b_sent = 0; c_got = 0; load_cyc = 0;
    load_seen = 0; c_seen = 0; stalled = 0; finished = 0; held = '0;
    pulse_start(m, k, n);
    check({name, "_busy_start"}, busy, 1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      a_tvalid = (a_sent < m*k) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      a_tdata  = DATA_W'(a_vec[a_sent % 64]);
      a_tlast  = (a_sent == a_last_idx);
      b_tvalid = (b_sent < k*n) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      b_tdata  = DATA_W'(b_vec[b_sent % 64]);
      b_tlast  = (b_sent == k*n - 1);
      c_tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge clk);
      a_f = a_tvalid && a_tready;
      b_f = b_tvalid && b_tready;
      c_f = c_tvalid && c_tready;
      if (stalled) check({name, "_hold"}, c_tdata, held);
      stalled = c_tvalid && !c_tready;
      held = c_tdata;
      if (c_tvalid && !c_seen) begin
        c_seen = 1;
        check({name, "_first_c_latency"}, cyc - load_cyc, k + 2);
      end
      if (c_f) begin
        $display("%s C[%0d] data=%0d last=%0b", name, c_got, signed'(c_tdata), c_tlast);
        check({name, "_c_data"}, longint'(signed'(c_tdata)), c_exp[c_got % 64]);
        check({name, "_c_last"}, c_tlast, (c_got == m*n - 1));
        c_got++;
      end
      if (a_f) a_sent++;
      if (b_f) b_sent++;
      if (!load_seen && a_sent == m*k && b_sent == k*n) begin
        load_seen = 1;
        load_cyc = cyc;
      end
      if (done) begin
        finished = 1;
        break;
      end
      @(posedge clk); #1;
      if (rst_after > 0 && load_seen && cyc == load_cyc + rst_after) begin
        rst = 1'b1;
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs({name, "_rst"});
        check({name, "_no_c_beat"}, c_got, 0);
        return;
      end
    end
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
    c_tready = 1'b0;
    check({name, "_finished"}, finished, 1);
    check({name, "_c_count"}, c_got, m*n);
    check({name, "_a_beats"}, a_sent, m*k);
    check({name, "_status"}, status, exp_status);
    check({name, "_busy_end"}, busy, 0);
    check({name, "_ready_end"}, {a_tready, b_tready}, 0);
    check({name, "_valid_end"}, c_tvalid, 0);
  endtask

  task automatic bad_cfg(input string name, input int m, input int k, input int n);
    a_tvalid = 1'b1;
    b_tvalid = 1'b1;
    pulse_start(m, k, n);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({name, "_a_ready"}, a_tready, 0);
      check({name, "_b_ready"}, b_tready, 0);
    end
    check({name, "_done"}, done, 1);
    check({name, "_status"}, status, 1);
    check({name, "_busy"}, busy, 0);
    @(posedge clk); #1;
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
  endtask

  task automatic load_test1();
    for (int i = 0; i < 4; i++) begin
      a_vec[i] = i;
      b_vec[i] = i;
    end
    c_exp[0] = 2; c_exp[1] = 3; c_exp[2] = 6; c_exp[3] = 11;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    cfg_m = '0; cfg_k = '0; cfg_n = '0;
    a_tvalid = 1'b0; a_tdata = '0; a_tlast = 1'b0;
    b_tvalid = 1'b0; b_tdata = '0; b_tlast = 1'b0;
    c_tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    #1 rst = 1'b0;

    load_test1();
    run_case("t1_2x2", 2, 2, 2, 0, 3, 0, 0);
    check("t1_done", done, 1);
    run_case("t2_random", 2, 2, 2, 1, 3, 0, 0);

    for (int i = 0; i < 4; i++) begin
      a_vec[i] = i + 1;
      b_vec[i] = 1;
    end
    c_exp[0] = 10;
    run_case("t3_1x4x1", 1, 4, 1, 0, 3, 0, 0);

    a_vec[0] = 1;  a_vec[1] = -2; a_vec[2] = 3;
    a_vec[3] = -4; a_vec[4] = 5;  a_vec[5] = -6;
    b_vec[0] = 7;  b_vec[1] = 8;  b_vec[2] = 9;
    c_exp[0] = 18; c_exp[1] = -42;
    run_case("neg_2x3x1", 2, 3, 1, 0, 5, 0, 0);

    bad_cfg("t4_k0", 2, 0, 2);
    bad_cfg("t4_m9", 9, 2, 2);

    a_vec[0] = 32767; a_vec[1] = 32767;
    b_vec[0] = 32767; b_vec[1] = 32767;
`ifdef SATURATE_EN
    c_exp[0] = 32767;
`else
    c_exp[0] = 2;
`endif
    run_case("t5_wrap", 1, 2, 1, 0, 1, 0, 0);

    load_test1();
    run_case("t6_rst", 2, 2, 2, 0, 3, 1, 0);
    run_case("t6_rerun", 2, 2, 2, 0, 3, 0, 0);

    run_case("t7_tlast", 2, 2, 2, 0, 1, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
